// File: rtl/hazard_sched_if.sv
// Hazard-scheduler bundle: D/E/M stage descriptors toward the scheduler, stall/flush controls back.
interface hazard_sched_if;
  logic [4:0]  a1_d;
  logic [4:0]  a2_d;
  logic        rs_used_d;
  logic        rt_used_d;
  logic [1:0]  tuse_rs_d;
  logic [1:0]  tuse_rt_d;
  logic        md_use_d;
  logic        eret_d;
  logic [4:0]  a3_e;
  logic [1:0]  tnew_e;
  logic        we_e;
  logic        epc_wr_e;
  logic        md_start_e;
  logic        md_div_e;
  logic [4:0]  a3_m;
  logic [1:0]  tnew_m;
  logic        we_m;
  logic        epc_wr_m;
  logic        exc_req;
  logic        stall_fd;
  logic        stall_de;
  logic        flush_all;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output a1_d, a2_d, rs_used_d, rt_used_d, tuse_rs_d, tuse_rt_d, md_use_d, eret_d,
           a3_e, tnew_e, we_e, epc_wr_e, md_start_e, md_div_e,
           a3_m, tnew_m, we_m, epc_wr_m, exc_req,
    input  stall_fd, stall_de, flush_all, md_busy, stall_cnt
  );

  modport slave (
    input  a1_d, a2_d, rs_used_d, rt_used_d, tuse_rs_d, tuse_rt_d, md_use_d, eret_d,
           a3_e, tnew_e, we_e, epc_wr_e, md_start_e, md_div_e,
           a3_m, tnew_m, we_m, epc_wr_m, exc_req,
    output stall_fd, stall_de, flush_all, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_sched.sv
// Hazard/flush scheduler: stall and flush are combinational, the mult/div busy counter and stall counter are registered.
// Stall holds F/D and bubbles D/E; an exception flush overrides any stall in the same cycle.
module hazard_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic          clk,
  input  logic          reset,
  hazard_sched_if.slave hz
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] md_cnt;
  logic [31:0]      stall_q;
  logic             haz_rs;
  logic             haz_rt;
  logic             haz_md;
  logic             haz_eret;
  logic             stall;

  // A producer only blocks when its value arrives later than the consumer needs it.
  always_comb begin
    haz_rs = hz.rs_used_d && (hz.a1_d != 5'd0) &&
             ((hz.we_e && (hz.a1_d == hz.a3_e) && (hz.tuse_rs_d < hz.tnew_e)) ||
              (hz.we_m && (hz.a1_d == hz.a3_m) && (hz.tuse_rs_d < hz.tnew_m)));
    haz_rt = hz.rt_used_d && (hz.a2_d != 5'd0) &&
             ((hz.we_e && (hz.a2_d == hz.a3_e) && (hz.tuse_rt_d < hz.tnew_e)) ||
              (hz.we_m && (hz.a2_d == hz.a3_m) && (hz.tuse_rt_d < hz.tnew_m)));
    haz_md   = hz.md_use_d && ((md_cnt != '0) || hz.md_start_e);
    haz_eret = hz.eret_d && (hz.epc_wr_e || hz.epc_wr_m);
  end

  assign stall        = (haz_rs || haz_rt || haz_md || haz_eret) && !hz.exc_req;
  assign hz.stall_fd  = stall;
  assign hz.stall_de  = stall;
  assign hz.flush_all = hz.exc_req;
  assign hz.md_busy   = (md_cnt != '0);
  assign hz.stall_cnt = stall_q;

  // An op already running finishes even across an exception; only a new issue is squashed.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt  <= '0;
      stall_q <= '0;
    end else begin
      if (stall) begin
        stall_q <= stall_q + 32'd1;
      end
      if (hz.md_start_e && !hz.exc_req) begin
        md_cnt <= hz.md_div_e ? DIV_LD : MULT_LD;
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_sched_if hif();

  hazard_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hif)
  );

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic       rs_used;
    logic       rt_used;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       md_use;
    logic       eret;
    logic [4:0] a3_e;
    logic [1:0] tnew_e;
    logic       we_e;
    logic       epc_e;
    logic       md_start;
    logic       md_div;
    logic [4:0] a3_m;
    logic [1:0] tnew_m;
    logic       we_m;
    logic       epc_m;
    logic       exc;
  } in_t;

  typedef struct {
    in_t  in;
    logic st;
    logic fl;
  } tvec_t;

  int n_vec = 0;
  int n_err = 0;
  int n_cmp = 0;

  // Reference state: the mult/div unit is busy through cycle busy_until.
  longint      cyc = 0;
  longint      busy_until = -1;
  int unsigned m_cnt = 0;

  logic        s_stall, s_stall_de, s_flush, s_busy;
  logic [31:0] s_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic in_t dv(input logic [4:0] a1, input logic rsu, input logic [1:0] tus,
                             input logic [4:0] a2, input logic rtu, input logic [1:0] tut,
                             input logic [4:0] a3e, input logic wee, input logic [1:0] tne,
                             input logic [4:0] a3m, input logic wem, input logic [1:0] tnm);
    in_t v;
    v = '0;
    v.a1 = a1; v.rs_used = rsu; v.tuse_rs = tus;
    v.a2 = a2; v.rt_used = rtu; v.tuse_rt = tut;
    v.a3_e = a3e; v.we_e = wee; v.tnew_e = tne;
    v.a3_m = a3m; v.we_m = wem; v.tnew_m = tnm;
    return v;
  endfunction

  // Any read source that a later-arriving producer will write is a hazard.
  function automatic logic m_hazard(input in_t v, input logic busy);
    logic       h;
    logic [4:0] pa[2];
    logic [1:0] pt[2];
    logic       pw[2];
    logic [4:0] src;
    logic [1:0] tu;
    logic       used;
    h = 1'b0;
    pa = '{v.a3_e, v.a3_m};
    pt = '{v.tnew_e, v.tnew_m};
    pw = '{v.we_e, v.we_m};
    for (int s = 0; s < 2; s++) begin
      src  = (s == 0) ? v.a1 : v.a2;
      tu   = (s == 0) ? v.tuse_rs : v.tuse_rt;
      used = (s == 0) ? v.rs_used : v.rt_used;
      if (used && src != 5'd0)
        for (int p = 0; p < 2; p++)
          if (pw[p] && pa[p] == src && tu < pt[p]) h = 1'b1;
    end
    if (v.md_use && (busy || v.md_start)) h = 1'b1;
    if (v.eret && (v.epc_e || v.epc_m)) h = 1'b1;
    return h;
  endfunction

  task automatic drive(input in_t v);
    hif.a1_d = v.a1;           hif.a2_d = v.a2;
    hif.rs_used_d = v.rs_used; hif.rt_used_d = v.rt_used;
    hif.tuse_rs_d = v.tuse_rs; hif.tuse_rt_d = v.tuse_rt;
    hif.md_use_d = v.md_use;   hif.eret_d = v.eret;
    hif.a3_e = v.a3_e;         hif.tnew_e = v.tnew_e;
    hif.we_e = v.we_e;         hif.epc_wr_e = v.epc_e;
    hif.md_start_e = v.md_start; hif.md_div_e = v.md_div;
    hif.a3_m = v.a3_m;         hif.tnew_m = v.tnew_m;
    hif.we_m = v.we_m;         hif.epc_wr_m = v.epc_m;
    hif.exc_req = v.exc;
  endtask

  // Apply one vector for one cycle: compare against the reference, then advance it past the edge.
  task automatic step(input in_t v);
    logic busy_e, st_e;
    drive(v);
    #1;
    busy_e = (cyc <= busy_until);
    st_e   = m_hazard(v, busy_e) && !v.exc;
    s_stall = hif.stall_fd; s_stall_de = hif.stall_de; s_flush = hif.flush_all;
    s_busy  = hif.md_busy;  s_cnt = hif.stall_cnt;
    n_vec++;
    check("stall_fd", s_stall, st_e);
    check("stall_de", s_stall_de, st_e);
    check("flush_all", s_flush, v.exc);
    check("md_busy", s_busy, busy_e);
    check("stall_cnt", s_cnt, m_cnt);
    @(posedge clk);
    if (st_e) m_cnt++;
    if (v.md_start && !v.exc) busy_until = cyc + (v.md_div ? DIV_N : MULT_N);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive('0);
    reset = 1'b1;
    @(posedge clk);
    m_cnt = 0;
    busy_until = cyc;
    cyc++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    in_t         v;
    tvec_t       tab[$];
    logic [31:0] c0;

    tab.push_back('{dv(8,1,1, 0,0,0, 8,1,2, 0,0,0), 1'b1, 1'b0});
    tab.push_back('{dv(0,1,0, 0,0,0, 0,1,2, 0,0,0), 1'b0, 1'b0});
    tab.push_back('{dv(0,0,0, 8,0,0, 8,1,2, 0,0,0), 1'b0, 1'b0});
    tab.push_back('{dv(0,0,0, 9,1,0, 0,0,0, 9,1,1), 1'b1, 1'b0});
    tab.push_back('{dv(8,1,2, 0,0,0, 8,1,2, 0,0,0), 1'b0, 1'b0});
    tab.push_back('{dv(8,1,0, 0,0,0, 8,1,0, 0,0,0), 1'b0, 1'b0});
    tab.push_back('{dv(8,1,0, 0,0,0, 8,0,2, 0,0,0), 1'b0, 1'b0});
    tab.push_back('{dv(5,1,1, 0,0,0, 6,1,2, 0,0,0), 1'b0, 1'b0});
    tab.push_back('{dv(0,0,0, 7,1,1, 0,0,0, 7,1,2), 1'b1, 1'b0});
    v = dv(8,1,0, 0,0,0, 0,0,0, 8,1,1); v.exc = 1'b1;
    tab.push_back('{v, 1'b0, 1'b1});
    tab.push_back('{dv(0,0,0, 3,1,0, 3,1,1, 0,0,0), 1'b1, 1'b0});
    tab.push_back('{dv(4,1,0, 0,0,0, 0,0,0, 4,0,1), 1'b0, 1'b0});
    v = '0; v.md_use = 1'b1; v.md_start = 1'b1; v.exc = 1'b1;
    tab.push_back('{v, 1'b0, 1'b1});
    v = '0; v.md_use = 1'b1;
    tab.push_back('{v, 1'b0, 1'b0});
    v = '0; v.eret = 1'b1; v.epc_e = 1'b1;
    tab.push_back('{v, 1'b1, 1'b0});
    v = '0; v.eret = 1'b1; v.epc_m = 1'b1; v.exc = 1'b1;
    tab.push_back('{v, 1'b0, 1'b1});
    v = '0; v.eret = 1'b1;
    tab.push_back('{v, 1'b0, 1'b0});
    v = '0; v.epc_e = 1'b1; v.epc_m = 1'b1;
    tab.push_back('{v, 1'b0, 1'b0});

    do_reset();
    step('0);
    check("reset_busy", s_busy, 1'b0);
    check("reset_cnt", s_cnt, 32'd0);

    foreach (tab[i]) begin
      step(tab[i].in);
      check($sformatf("tab%0d_stall", i), s_stall, tab[i].st);
      check($sformatf("tab%0d_flush", i), s_flush, tab[i].fl);
    end

    // Load-use: stall while the load is in E, released once it reaches M.
    step(dv(8,1,1, 0,0,0, 8,1,2, 0,0,0));
    check("lw_stall", s_stall, 1'b1);
    c0 = s_cnt;
    step(dv(8,1,1, 0,0,0, 0,0,0, 8,1,1));
    check("lw_release", s_stall, 1'b0);
    check("lw_cnt_inc", s_cnt, c0 + 32'd1);

    // Divide followed by mflo: stalled t..t+10, released at t+11.
    v = '0; v.md_use = 1'b1; v.md_start = 1'b1; v.md_div = 1'b1;
    step(v);
    check("div_stall_0", s_stall, 1'b1);
    check("div_busy_0", s_busy, 1'b0);
    v = '0; v.md_use = 1'b1;
    for (int k = 1; k <= DIV_N + 1; k++) begin
      step(v);
      check($sformatf("div_stall_%0d", k), s_stall, k <= DIV_N);
      check($sformatf("div_busy_%0d", k), s_busy, k <= DIV_N);
    end

    // Mult squashed by a same-cycle exception never starts.
    v = '0; v.md_start = 1'b1; v.md_use = 1'b1; v.exc = 1'b1;
    step(v);
    check("mexc_flush", s_flush, 1'b1);
    check("mexc_stall", s_stall, 1'b0);
    step('0);
    check("mexc_busy", s_busy, 1'b0);

    // Exception while a mult is running leaves it to drain.
    v = '0; v.md_start = 1'b1;
    step(v);
    step('0);
    step('0);
    v = '0; v.exc = 1'b1;
    step(v);
    check("mrun_flush", s_flush, 1'b1);
    check("mrun_busy3", s_busy, 1'b1);
    step('0);
    check("mrun_busy2", s_busy, 1'b1);
    step('0);
    check("mrun_busy1", s_busy, 1'b1);
    step('0);
    check("mrun_idle", s_busy, 1'b0);

    v = '0; v.eret = 1'b1; v.epc_m = 1'b1;
    step(v);
    check("eret_stall", s_stall, 1'b1);
    v.exc = 1'b1;
    step(v);
    check("eret_exc_stall", s_stall, 1'b0);
    check("eret_exc_flush", s_flush, 1'b1);

    // Reset in the middle of a divide.
    v = '0; v.md_start = 1'b1; v.md_div = 1'b1;
    step(v);
    step('0);
    step('0);
    do_reset();
    step('0);
    check("rst_mid_busy", s_busy, 1'b0);
    check("rst_mid_cnt", s_cnt, 32'd0);

    // Random traffic over a few registers so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        v = '0;
        v.a1 = 5'($urandom_range(0, 3));       v.a2 = 5'($urandom_range(0, 3));
        v.rs_used = 1'($urandom);              v.rt_used = 1'($urandom);
        v.tuse_rs = 2'($urandom_range(0, 2));  v.tuse_rt = 2'($urandom_range(0, 2));
        v.a3_e = 5'($urandom_range(0, 3));     v.a3_m = 5'($urandom_range(0, 3));
        v.tnew_e = 2'($urandom);               v.tnew_m = 2'($urandom);
        v.we_e = 1'($urandom);                 v.we_m = 1'($urandom);
        v.md_use = ($urandom_range(0, 2) == 0);
        v.md_start = ($urandom_range(0, 7) == 0);
        v.md_div = 1'($urandom);
        v.eret = ($urandom_range(0, 3) == 0);
        v.epc_e = ($urandom_range(0, 3) == 0); v.epc_m = ($urandom_range(0, 3) == 0);
        v.exc = ($urandom_range(0, 15) == 0);
        step(v);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
